pulse_meter: RTL and testbench

- Measures the rate of a slow external pulse train, such as the divided tick from a clock divider or counter LSB, by counting its rising edges over a fixed gate window of system clocks.
- At the end of each window it latches the count and presents it with a valid/ack handshake.
- It is the observing end of divided-clock generators and is used for self-check and bring-up of prescaled clock chains.

---
 rtl/pulse_meter_pkg.sv | 8 +
 rtl/sync_edge_detect.sv | 26 ++
 rtl/pulse_meter.sv | 98 +++++++++
 tb/tb_pulse_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared constants for the pulse rate meter.
// State encoding of the measurement FSM.
package pulse_meter_pkg;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_MEASURE = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a history flop.
// rise pulses for one clk per synchronised rising edge.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/pulse_meter.sv
// Counts rising edges of sig_in over a fixed gate window
// and presents each window's count with a valid/ack handshake.
module pulse_meter
   import pulse_meter_pkg::*;
#(
   parameter int GATE_CYCLES = 1000,
   parameter int GATE_WIDTH  = 10,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   sig_in,
   input  logic                   ack,
   output logic [COUNT_WIDTH-1:0] result,
   output logic                   valid,
   output logic                   overflow,
   output logic                   missed
);

   localparam logic [GATE_WIDTH-1:0] GATE_LAST =
      GATE_WIDTH'(GATE_CYCLES - 1);

   logic                   rise;
   logic                   state;
   logic [GATE_WIDTH-1:0]  gate_cnt;
   logic [COUNT_WIDTH-1:0] edge_cnt;
   logic                   sat;
   logic                   at_max;

   sync_edge_detect u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .rise   (rise)
   );

   assign at_max = &edge_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         result   <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
         missed   <= 1'b0;
      end else begin
         if (ack && valid) begin
            valid  <= 1'b0;
            missed <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               gate_cnt <= '0;
               edge_cnt <= '0;
               sat      <= 1'b0;
               // The entry cycle is already gate cycle 0.
               if (en) begin
                  state    <= ST_MEASURE;
                  gate_cnt <= GATE_WIDTH'(1);
                  edge_cnt <= COUNT_WIDTH'(rise);
               end
            end
            ST_MEASURE: begin
               if (!en) begin
                  state    <= ST_IDLE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else if (gate_cnt == GATE_LAST) begin
                  result   <= at_max ? edge_cnt
                            : edge_cnt + COUNT_WIDTH'(rise);
                  overflow <= sat | (rise & at_max);
                  valid    <= 1'b1;
                  if (valid && !ack)
                     missed <= 1'b1;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end else begin
                  gate_cnt <= gate_cnt + GATE_WIDTH'(1);
                  if (rise) begin
                     if (at_max)
                        sat <= 1'b1;
                     else
                        edge_cnt <= edge_cnt + COUNT_WIDTH'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: two instances (10-cycle/8-bit and
// 40-cycle/2-bit) against a window-level reference model.
module tb_pulse_meter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       sig_in = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] res_a;
   logic       val_a, ovf_a, mis_a;
   logic [1:0] res_b;
   logic       val_b, ovf_b, mis_b;

   int checks = 0;
   int errors = 0;

   pulse_meter #(
      .GATE_CYCLES (10),
      .GATE_WIDTH  (4),
      .COUNT_WIDTH (8)
   ) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sig_in   (sig_in),
      .ack      (ack),
      .result   (res_a),
      .valid    (val_a),
      .overflow (ovf_a),
      .missed   (mis_a)
   );

   pulse_meter #(
      .GATE_CYCLES (40),
      .GATE_WIDTH  (6),
      .COUNT_WIDTH (2)
   ) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sig_in   (sig_in),
      .ack      (ack),
      .result   (res_b),
      .valid    (val_b),
      .overflow (ovf_b),
      .missed   (mis_b)
   );

   always #5 clk = ~clk;

   // Reference model: sampled-input history plus per-instance
   // window bookkeeping with an unbounded integer edge count.
   int gc [2] = '{10, 40};
   int mx [2] = '{255, 3};
   bit h [3];
   bit act [2];
   int pos [2];
   int cnt [2];
   int e_res [2];
   bit e_val [2];
   bit e_ovf [2];
   bit e_mis [2];

   task automatic model_edge();
      bit rs;
      bit ge;
      int fin;
      rs = h[1] & ~h[2];
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) h[i] = 1'b0;
         for (int d = 0; d < 2; d++) begin
            act[d] = 0; pos[d] = 0; cnt[d] = 0;
            e_res[d] = 0; e_val[d] = 0;
            e_ovf[d] = 0; e_mis[d] = 0;
         end
         return;
      end
      h[2] = h[1];
      h[1] = h[0];
      h[0] = sig_in;
      for (int d = 0; d < 2; d++) begin
         ge = 0;
         fin = 0;
         if (!act[d]) begin
            if (en) begin
               act[d] = 1; pos[d] = 1; cnt[d] = int'(rs);
            end
         end else if (!en) begin
            act[d] = 0;
         end else begin
            cnt[d] += int'(rs);
            if (pos[d] == gc[d] - 1) begin
               ge = 1; fin = cnt[d];
               pos[d] = 0; cnt[d] = 0;
            end else begin
               pos[d]++;
            end
         end
         if (ge) begin
            if (e_val[d]) e_mis[d] = !ack;
            e_res[d] = (fin > mx[d]) ? mx[d] : fin;
            e_ovf[d] = (fin > mx[d]);
            e_val[d] = 1;
         end else if (ack && e_val[d]) begin
            e_val[d] = 0;
            e_mis[d] = 0;
         end
      end
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic compare();
      check("a_result", 32'(res_a), 32'(e_res[0]));
      check("a_valid", 32'(val_a), 32'(e_val[0]));
      check("a_overflow", 32'(ovf_a), 32'(e_ovf[0]));
      check("a_missed", 32'(mis_a), 32'(e_mis[0]));
      check("b_result", 32'(res_b), 32'(e_res[1]));
      check("b_valid", 32'(val_b), 32'(e_val[1]));
      check("b_overflow", 32'(ovf_b), 32'(e_ovf[1]));
      check("b_missed", 32'(mis_b), 32'(e_mis[1]));
   endtask

   task automatic step(input logic r, input logic e,
                       input logic s, input logic a);
      rst_n  = r;
      en     = e;
      sig_in = s;
      ack    = a;
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   initial begin
      // Reset with sig_in toggling.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 1'(i % 2), 1'b0);
      check("rst_result", 32'(res_a), 32'd0);
      check("rst_valid", 32'(val_a), 32'd0);
      check("rst_missed", 32'(mis_b), 32'd0);

      // Idle with en low.
      for (int i = 0; i < 50; i++)
         step(1'b1, 1'b0, 1'($urandom % 2), 1'b0);
      check("idle_valid", 32'(val_a), 32'd0);

      // Three isolated pulses: rises on window cycles 0, 4, 8.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = -3; k <= 12; k++) begin
         step(1'b1, 1'(k >= 0),
              1'(k == -2 || k == -1 || k == 2 ||
                 k == 3 || k == 6 || k == 7), 1'b0);
         if (k == 8) check("three_novalid", 32'(val_a), 32'd0);
         if (k == 9) begin
            check("three_result", 32'(res_a), 32'd3);
            check("three_valid", 32'(val_a), 32'd1);
            check("three_ovf", 32'(ovf_a), 32'd0);
         end
      end

      // Window boundary and handshake.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 50; k++) begin
         step(1'b1, 1'b1, 1'(k == 7 || k == 18),
              1'(k == 31 || k == 49));
         if (k == 9) check("edge_last", 32'(res_a), 32'd1);
         if (k == 19) begin
            check("edge_next_w1", 32'(res_a), 32'd0);
            check("missed_set", 32'(mis_a), 32'd1);
         end
         if (k == 29) check("edge_first", 32'(res_a), 32'd1);
         if (k == 31) begin
            check("ack_valid", 32'(val_a), 32'd0);
            check("ack_missed", 32'(mis_a), 32'd0);
         end
         if (k == 49) begin
            check("ackge_valid", 32'(val_a), 32'd1);
            check("ackge_missed", 32'(mis_a), 32'd0);
         end
      end

      // Abort at window cycle 5, re-entry, then reset mid-window.
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 15; k++)
         step(1'b1, 1'(k < 5), 1'($urandom % 2), 1'b0);
      check("abort_valid", 32'(val_a), 32'd0);
      for (int k = 0; k < 15; k++) begin
         step(1'b1, 1'b1, 1'($urandom % 2), 1'b0);
         if (k == 8) check("reent_early", 32'(val_a), 32'd0);
         if (k == 9) check("reent_valid", 32'(val_a), 32'd1);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("midrst_valid", 32'(val_a), 32'd0);
      check("midrst_result", 32'(res_a), 32'd0);
      check("midrst_ovf", 32'(ovf_b), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

      // Saturation on the 2-bit instance.
      for (int k = 0; k < 80; k++) begin
         step(1'b1, 1'b1,
              1'((k < 24 && (k % 4) < 2) || k == 50 || k == 51),
              1'b0);
         if (k == 39) begin
            check("sat_result", 32'(res_b), 32'd3);
            check("sat_ovf", 32'(ovf_b), 32'd1);
         end
         if (k == 79) begin
            check("post_result", 32'(res_b), 32'd1);
            check("post_ovf", 32'(ovf_b), 32'd0);
         end
      end

      // Random traffic.
      for (int i = 0; i < 1500; i++)
         step(1'($urandom % 300 != 0), 1'($urandom % 60 != 0),
              1'($urandom % 2), 1'($urandom % 6 == 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
